jh_round_b_inv_iter: RTL and testbench

- Iterative inverse of the JH round-B function R. R is defined as: nibble S-box, then per-byte linear map, then byte-pair-to-nibble permutation.
- Used on the decrypt/check path to unwind up to 15 applications of R on a 256-bit state.
- One inverse round per clock, applied in place to a state register, behind valid/ready handshakes on input and output.

---
 rtl/jh_round_b_inv_iter.sv | 137 +++++++++++++
 tb/tb_jh_round_b_inv_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jh_round_b_inv_iter.sv
// Iterative inverse of the JH round-B function R on a 256-bit state.
// R = nibble S-box, then per-byte linear map (h,l) -> (f,g), then
// byte-pair-to-nibble permutation. This block undoes one R per clock,
// in place on state_q, for up to MAX_ROUNDS rounds per job.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid, in_ready  job handshake; in_ready high only while idle
//   in, rounds          state to invert and round count (0 = pass-through)
//   out_valid, out_ready result handshake; out held stable until accepted
//   out                 result state, driven straight from state_q
//   busy                high while running or holding a result
module jh_round_b_inv_iter #(
    parameter int unsigned MAX_ROUNDS = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in,
    input  logic [3:0]   rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out,
    output logic         busy
);

    localparam logic [3:0] MaxCnt = (MAX_ROUNDS > 15) ? 4'd15 : 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [255:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   cnt_init;
    logic [255:0] rinv_state;

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h8;
            4'h1: y = 4'h1;
            4'h2: y = 4'h5;
            4'h3: y = 4'h6;
            4'h4: y = 4'h4;
            4'h5: y = 4'hb;
            4'h6: y = 4'hd;
            4'h7: y = 4'h3;
            4'h8: y = 4'h7;
            4'h9: y = 4'h0;
            4'ha: y = 4'h9;
            4'hb: y = 4'hc;
            4'hc: y = 4'ha;
            4'hd: y = 4'h2;
            4'he: y = 4'hf;
            default: y = 4'he;
        endcase
        return y;
    endfunction

    // Recover (h,l) from (f,g): l first, since h depends on it; then undo the S-box.
    function automatic logic [7:0] byte_inv(input logic [3:0] f, input logic [3:0] g);
        logic [3:0] l;
        logic [3:0] t;
        l = g ^ {f[0], f[3] ^ f[0], f[2], f[1]};
        t = f ^ {l[3], l[0] ^ l[3], l[1], l[2]};
        return {sbox_inv({t[0], t[1], t[2], t[3]}), sbox_inv(l)};
    endfunction

    // Nibble Nk sits at bits [255-4k -: 4]; byte Bi at [255-8i -: 8].
    // Byte 2m:   f = N(32+2m), g = N(2m+1).
    // Byte 2m+1: f = N(2m),    g = N(33+2m).
    function automatic logic [255:0] rinv(input logic [255:0] s);
        logic [255:0] r;
        r = '0;
        for (int m = 0; m < 16; m++) begin
            r[255-16*m -: 8] = byte_inv(s[127-8*m -: 4], s[251-8*m -: 4]);
            r[247-16*m -: 8] = byte_inv(s[255-8*m -: 4], s[123-8*m -: 4]);
        end
        return r;
    endfunction

    always_comb begin
        rinv_state = rinv(state_q);
    end

    always_comb begin
        cnt_init = (rounds > MaxCnt) ? MaxCnt : rounds;
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in;
                    cnt_d   = cnt_init;
                    fsm_d   = (cnt_init == 4'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                state_d = rinv_state;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (fsm_q == StIdle);
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q != StIdle);
    assign out       = state_q;

endmodule

// File: tb/tb_jh_round_b_inv_iter.sv
module tb_jh_round_b_inv_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] din;
    logic [3:0]   rounds;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] dout;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    jh_round_b_inv_iter #(
        .MAX_ROUNDS(15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (din),
        .rounds   (rounds),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward reference model of R.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h9;
            4'h1: y = 4'h1;
            4'h2: y = 4'hd;
            4'h3: y = 4'h7;
            4'h4: y = 4'h4;
            4'h5: y = 4'h2;
            4'h6: y = 4'h3;
            4'h7: y = 4'h8;
            4'h8: y = 4'h0;
            4'h9: y = 4'ha;
            4'ha: y = 4'hc;
            4'hb: y = 4'h5;
            4'hc: y = 4'hb;
            4'hd: y = 4'h6;
            4'he: y = 4'hf;
            default: y = 4'he;
        endcase
        return y;
    endfunction

    function automatic logic [255:0] fwd_r(input logic [255:0] s);
        logic [255:0] r;
        logic [3:0]   fa [32];
        logic [3:0]   ga [32];
        logic [3:0]   h, l, f;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            h = sbox(s[255-8*b -: 4]);
            l = sbox(s[251-8*b -: 4]);
            f = {h[0], h[1], h[2], h[3]} ^ {l[3], l[0] ^ l[3], l[1], l[2]};
            fa[b] = f;
            ga[b] = l ^ {f[0], f[3] ^ f[0], f[2], f[1]};
        end
        for (int m = 0; m < 16; m++) begin
            r[255-4*(2*m)    -: 4] = fa[2*m+1];
            r[255-4*(2*m+1)  -: 4] = ga[2*m];
            r[255-4*(32+2*m) -: 4] = fa[2*m];
            r[255-4*(33+2*m) -: 4] = ga[2*m+1];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] fwd_n(input logic [255:0] s, input int k);
        logic [255:0] v;
        v = s;
        for (int i = 0; i < k; i++) v = fwd_r(v);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job from idle, wait (bounded) for out_valid; lat = edges after accept.
    task automatic run_job(input logic [255:0] s, input logic [3:0] r, output int lat);
        in_valid = 1'b1;
        din      = s;
        rounds   = r;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [255:0] all15, orig, exp_a, exp_b, pat;
    int           lat;
    int           k;

    initial begin
        all15 = {32{8'h15}};
        pat   = {4{64'h0123456789abcdef}};
        rst_n = 1'b0; in_valid = 1'b0; din = '0; rounds = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_out", dout, 256'd0);
        check("rst_in_ready_held", 256'(in_ready), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready_rel", 256'(in_ready), 256'd1);

        // 0x15.. is R(0): one inverse round gives zero.
        run_job(all15, 4'd1, lat);
        check("zero_lat", 256'(lat), 256'd1);
        check("zero_out", dout, 256'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("zero_hold_valid", 256'(out_valid), 256'd1);
            check("zero_hold_out", dout, 256'd0);
        end
        accept();
        check("zero_in_ready_after", 256'(in_ready), 256'd1);
        check("zero_valid_after", 256'(out_valid), 256'd0);

        // Two rounds: Rinv(0) is 0x88 in every byte.
        run_job(all15, 4'd2, lat);
        check("two_lat", 256'(lat), 256'd2);
        check("two_out", dout, {32{8'h88}});
        accept();

        // Pass-through.
        run_job(pat, 4'd0, lat);
        check("pass_lat", 256'(lat), 256'd0);
        check("pass_out", dout, pat);
        accept();

        // Round trips against the forward model.
        for (int i = 0; i < 1002; i++) begin
            k = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 7 : 15);
            orig = rand256();
            run_job(fwd_n(orig, k), 4'(k), lat);
            check("rt_lat", 256'(lat), 256'(k));
            check("rt_out", dout, orig);
            accept();
        end

        // Max rounds with junk offered mid-run and a long stall.
        orig = rand256();
        in_valid = 1'b1; din = fwd_n(orig, 15); rounds = 4'd15;
        tick();
        in_valid = 1'b0;
        tick();
        lat = 1;
        check("bp_in_ready_run", 256'(in_ready), 256'd0);
        in_valid = 1'b1; din = ~din; rounds = 4'd3;
        tick();
        lat = 2;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_lat", 256'(lat), 256'd15);
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", 256'(out_valid), 256'd1);
            check("bp_out", dout, orig);
            check("bp_in_ready", 256'(in_ready), 256'd0);
            in_valid = (c == 5);
            din      = rand256();
            tick();
        end
        in_valid = 1'b0;
        accept();
        check("bp_in_ready_after", 256'(in_ready), 256'd1);
        check("bp_busy_after", 256'(busy), 256'd0);

        // Reset in the third run cycle of a 10-round job.
        orig = rand256();
        in_valid = 1'b1; din = fwd_n(orig, 10); rounds = 4'd10;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_valid", 256'(out_valid), 256'd0);
        check("mid_rst_out", dout, 256'd0);
        check("mid_rst_in_ready", 256'(in_ready), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rel_in_ready", 256'(in_ready), 256'd1);
        repeat (12) tick();
        check("mid_no_partial", 256'(out_valid), 256'd0);
        orig = rand256();
        run_job(fwd_n(orig, 7), 4'd7, lat);
        check("mid_fresh_lat", 256'(lat), 256'd7);
        check("mid_fresh_out", dout, orig);
        accept();

        // Back-to-back with out_ready tied high.
        orig  = rand256();
        exp_b = rand256();
        exp_a = orig;
        out_ready = 1'b1;
        in_valid = 1'b1; din = fwd_n(exp_a, 1); rounds = 4'd1;
        tick();
        din = fwd_n(exp_b, 2); rounds = 4'd2;
        begin
            logic [5:0] ev_valid;
            logic [5:0] ev_ready;
            ev_valid = 6'b100010;  // edges 1..6, LSB = edge 1
            ev_ready = 6'b100010;
            ev_valid = 6'b010001;
            ev_ready = 6'b100010;
            for (int e = 0; e < 6; e++) begin
                tick();
                if (e == 4) in_valid = 1'b0;
                check("b2b_valid", 256'(out_valid), 256'(ev_valid[e]));
                check("b2b_in_ready", 256'(in_ready), 256'(ev_ready[e]));
                if (e == 0) check("b2b_out_a", dout, exp_a);
                if (e == 4) check("b2b_out_b", dout, exp_b);
            end
        end
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
